// File: rtl/nroot_pkg.sv
// Shared types and helpers for the nroot_iter integer root unit.
package nroot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRY,
        MUL,
        CMP,
        DONE
    } state_t;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_CBRT = 1'b1;

    // Result bits that must be searched for each root mode.
    function automatic int nb_sqrt(input int width);
        return (width + 1) / 2;
    endfunction

    function automatic int nb_cbrt(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/nroot_mul.sv
// Shift-add multiplier: loads on start, then takes exactly RW cycles to form a*b (truncated to PW).
module nroot_mul #(
    parameter int PW = 32,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] a,
    input  logic [RW-1:0] b,
    output logic          busy,
    output logic          last,
    output logic [PW-1:0] p
);
    localparam int CW = $clog2(RW + 1);

    logic [PW-1:0] mcand;
    logic [RW-1:0] mplier;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            p      <= '0;
        end else if (start && !busy) begin
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(RW);
            busy   <= 1'b1;
            p      <= '0;
        end else if (busy) begin
            if (mplier[0])
                p <= p + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

    // High in the final compute cycle; p holds the full product from the next cycle on.
    assign last = busy && (cnt == CW'(1));

endmodule

// File: rtl/nroot_iter.sv
// Iterative floor sqrt/cbrt using an MSB-first candidate search and a shift-add multiplier.
// Optional macro ROOT_REM_EN adds the rem_bo output (x - y^n).
module nroot_iter
    import nroot_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int RW    = (WIDTH + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_bi,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    y_bo
`ifdef ROOT_REM_EN
    ,
    output logic [WIDTH-1:0] rem_bo
`endif
);
    localparam int NB_SQ = nb_sqrt(WIDTH);
    localparam int NB_CB = nb_cbrt(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam int KW    = (RW > 1) ? $clog2(RW) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x_r;
    logic             mode_r;
    logic [RW-1:0]    res;
    logic [RW-1:0]    cand;
    logic [KW-1:0]    k;
    logic [1:0]       mul_left;
    logic [1:0]       mul_total;
    logic             mul_start, mul_busy, mul_last;
    logic [PW-1:0]    mul_a, mul_p;
`ifdef ROOT_REM_EN
    logic [WIDTH-1:0] acc_pow;
`endif

    assign mul_total = (mode_r == MODE_CBRT) ? 2'd2 : 2'd1;
    // First multiply of a candidate squares cand; a cube chains the previous product.
    assign mul_a     = (mul_left == mul_total) ? PW'(cand) : mul_p;
    assign busy      = (state != IDLE);

    nroot_mul #(.PW(PW), .RW(RW)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (cand),
        .busy  (mul_busy),
        .last  (mul_last),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = TRY;
            TRY:  state_nxt = MUL;
            MUL: begin
                mul_start = !mul_busy;
                if (mul_last && mul_left == 2'd1)
                    state_nxt = CMP;
            end
            CMP:  state_nxt = (k == '0) ? DONE : TRY;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r      <= '0;
            mode_r   <= MODE_SQRT;
            res      <= '0;
            cand     <= '0;
            k        <= '0;
            mul_left <= '0;
            done     <= 1'b0;
            y_bo     <= '0;
`ifdef ROOT_REM_EN
            acc_pow  <= '0;
            rem_bo   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_r    <= x_bi;
                    mode_r <= mode;
                    res    <= '0;
                    k      <= (mode == MODE_CBRT) ? KW'(NB_CB - 1) : KW'(NB_SQ - 1);
`ifdef ROOT_REM_EN
                    acc_pow <= '0;
`endif
                end
                TRY: begin
                    cand     <= res | (RW'(1) << k);
                    mul_left <= mul_total;
                end
                MUL: if (mul_last) mul_left <= mul_left - 2'd1;
                CMP: begin
                    if (mul_p <= PW'(x_r)) begin
                        res <= cand;
`ifdef ROOT_REM_EN
                        acc_pow <= mul_p[WIDTH-1:0];
`endif
                    end
                    if (k != '0)
                        k <= k - KW'(1);
                end
                DONE: begin
                    y_bo <= res;
                    done <= 1'b1;
`ifdef ROOT_REM_EN
                    rem_bo <= x_r - acc_pow;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nroot_iter.sv
// Bench for nroot_iter: WIDTH=16 and WIDTH=8 instances checked against an arithmetic root model.
module tb_nroot_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, mode16, busy16, done16;
    logic [15:0] x16;
    logic [7:0]  y16;
    logic        start8, mode8, busy8, done8;
    logic [7:0]  x8;
    logic [3:0]  y8;
`ifdef ROOT_REM_EN
    logic [15:0] rem16;
    logic [7:0]  rem8;
`endif

    int n_vec = 0;
    int n_err = 0;
    int done_cnt16 = 0;
    int done_cnt8 = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done16) done_cnt16++;
        if (done8)  done_cnt8++;
    end

    nroot_iter #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .mode  (mode16),
        .x_bi  (x16),
        .busy  (busy16),
        .done  (done16),
        .y_bo  (y16)
`ifdef ROOT_REM_EN
        ,
        .rem_bo(rem16)
`endif
    );

    nroot_iter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .mode  (mode8),
        .x_bi  (x8),
        .busy  (busy8),
        .done  (done8),
        .y_bo  (y8)
`ifdef ROOT_REM_EN
        ,
        .rem_bo(rem8)
`endif
    );

    // Reference model: plain arithmetic on the definition of the floor root.
    function automatic longint pw(input longint v, input bit m);
        return m ? v * v * v : v * v;
    endfunction

    function automatic int ref_root(input int xv, input bit m);
        int y = 0;
        while (pw(longint'(y + 1), m) <= longint'(xv)) y++;
        return y;
    endfunction

    function automatic int ref_lat(input int w, input bit m);
        int rw = (w + 1) / 2;
        int nb = m ? (w + 2) / 3 : (w + 1) / 2;
        int nm = m ? 2 : 1;
        return nb * (2 + nm * (rw + 1)) + 1;
    endfunction

    // Issue one request, wait for done (bounded), return result and accept-to-done cycles.
    task automatic run_op(input bit w8, input bit m, input int xv,
                          output int y, output int rem, output int cyc);
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; mode8 = m; x8 = xv[7:0];
        end else begin
            start16 = 1'b1; mode16 = m; x16 = xv[15:0];
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!(w8 ? done8 : done16) && cyc < 400);
        y   = w8 ? int'(y8) : int'(y16);
        rem = 0;
`ifdef ROOT_REM_EN
        rem = w8 ? int'(rem8) : int'(rem16);
`endif
        @(posedge clk);
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
        n_vec++; if (done16 !== 1'b0) begin n_err++; $display("FAIL reset_done16 got=%b exp=0", done16); end
        n_vec++; if (y16 !== 8'd0) begin n_err++; $display("FAIL reset_y16 got=%0d exp=0", y16); end
        n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        n_vec++; if (y8 !== 4'd0) begin n_err++; $display("FAIL reset_y8 got=%0d exp=0", y8); end
`ifdef ROOT_REM_EN
        n_vec++; if (rem16 !== 16'd0) begin n_err++; $display("FAIL reset_rem16 got=%0d exp=0", rem16); end
`endif
        #20 rst = 1'b1;
    endtask

    task automatic test_boundaries;
        int bx[11] = '{65535, 64000, 63999, 0, 1, 0, 1, 255, 255, 65535, 0};
        bit bm[11] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
        bit bw[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
        int by[11] = '{255, 40, 39, 0, 1, 0, 1, 15, 6, 40, 0};
        int br[11] = '{510, 0, 4680, 0, 0, 0, 0, 30, 39, 1535, 0};
        int y, rem, cyc, w;
        for (int i = 0; i < 11; i++) begin
            w = bw[i] ? 8 : 16;
            run_op(bw[i], bm[i], bx[i], y, rem, cyc);
            n_vec++;
            if (y != by[i]) begin
                n_err++; $display("FAIL bound_y x=%0d m=%0d w=%0d got=%0d exp=%0d", bx[i], bm[i], w, y, by[i]);
            end
            n_vec++;
            if (cyc != ref_lat(w, bm[i])) begin
                n_err++; $display("FAIL bound_lat x=%0d m=%0d w=%0d got=%0d exp=%0d", bx[i], bm[i], w, cyc, ref_lat(w, bm[i]));
            end
`ifdef ROOT_REM_EN
            n_vec++;
            if (rem != br[i]) begin
                n_err++; $display("FAIL bound_rem x=%0d m=%0d w=%0d got=%0d exp=%0d", bx[i], bm[i], w, rem, br[i]);
            end
`endif
            #1;
            n_vec++;
            if ((bw[i] ? done8 : done16) !== 1'b0) begin
                n_err++; $display("FAIL done_width x=%0d got=1 exp=0", bx[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat = ref_lat(16, 1'b0);
        int d0;
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b0; x16 = 16'd40000;
        @(negedge clk);
        start16 = 1'b0;
        d0 = done_cnt16;
        for (int c = 1; c <= lat + 4; c++) begin
            start16 = (c == 3 || c == 20 || c == 50 || c == lat);
            mode16  = start16;
            x16     = start16 ? 16'd9 : 16'd40000;
            @(posedge clk);
            @(negedge clk);
        end
        start16 = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (done_cnt16 - d0 != 1) begin n_err++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt16 - d0); end
        n_vec++; if (y16 !== 8'd200) begin n_err++; $display("FAIL ignore_y got=%0d exp=200", y16); end
        n_vec++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL ignore_busy got=%b exp=0", busy16); end
    endtask

    task automatic test_async_reset;
        int xv = int'($urandom_range(1000, 65535));
        int d0, y, rem, cyc;
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b0; x16 = xv[15:0];
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        d0 = done_cnt16;
        #1;
        n_vec++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", busy16); end
        n_vec++; if (done16 !== 1'b0) begin n_err++; $display("FAIL arst_done got=%b exp=0", done16); end
        n_vec++; if (y16 !== 8'd0) begin n_err++; $display("FAIL arst_y got=%0d exp=0", y16); end
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (done_cnt16 != d0) begin n_err++; $display("FAIL arst_no_done got=%0d exp=%0d", done_cnt16, d0); end
        n_vec++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL arst_idle got=%b exp=0", busy16); end
        xv = int'($urandom_range(0, 65535));
        run_op(1'b0, 1'b1, xv, y, rem, cyc);
        n_vec++; if (y != ref_root(xv, 1'b1)) begin n_err++; $display("FAIL arst_after x=%0d got=%0d exp=%0d", xv, y, ref_root(xv, 1'b1)); end
    endtask

    task automatic test_back_to_back;
        int xv, y, rem, cyc;
        for (int i = 0; i < 4; i++) begin
            xv = int'($urandom_range(0, 65535));
            run_op(1'b0, i[0], xv, y, rem, cyc);
            n_vec++;
            if (y != ref_root(xv, i[0]) || cyc != ref_lat(16, i[0])) begin
                n_err++; $display("FAIL b2b x=%0d got y=%0d cyc=%0d exp y=%0d cyc=%0d", xv, y, cyc, ref_root(xv, i[0]), ref_lat(16, i[0]));
            end
        end
    endtask

    task automatic test_random_sweep;
        int xv, y, rem, cyc, w;
        bit m, w8;
        for (int t = 0; t < 40; t++) begin
            w8 = t[0];
            m  = t[1];
            w  = w8 ? 8 : 16;
            xv = w8 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 65535));
            run_op(w8, m, xv, y, rem, cyc);
            n_vec++;
            if (!(pw(longint'(y), m) <= longint'(xv) && pw(longint'(y + 1), m) > longint'(xv))) begin
                n_err++; $display("FAIL sweep_root w=%0d m=%0d x=%0d got=%0d exp=%0d", w, m, xv, y, ref_root(xv, m));
            end
            n_vec++;
            if (cyc != ref_lat(w, m)) begin
                n_err++; $display("FAIL sweep_lat w=%0d m=%0d x=%0d got=%0d exp=%0d", w, m, xv, cyc, ref_lat(w, m));
            end
`ifdef ROOT_REM_EN
            n_vec++;
            if (longint'(rem) != longint'(xv) - pw(longint'(ref_root(xv, m)), m)) begin
                n_err++; $display("FAIL sweep_rem w=%0d m=%0d x=%0d got=%0d", w, m, xv, rem);
            end
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start16 = 1'b0; mode16 = 1'b0; x16 = '0;
        start8  = 1'b0; mode8  = 1'b0; x8  = '0;
        test_reset();
        test_boundaries();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nroot_iter.md
Name: nroot_iter

Overview:
- Parametrised iterative integer root unit: returns floor(sqrt(x)) or floor(cbrt(x)) for an unsigned WIDTH-bit operand.
- Mode is selected per request.
- Replaces the linear-search cube-root block with a bit-by-bit (MSB-first) candidate search. A private shift-add multiplier forms candidate powers.
- Sits on the arithmetic datapath behind a start/busy/done handshake; deterministic latency per mode.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- RW, derived localparam = (WIDTH+1)/2, result port width (sqrt worst case).
- NB_SQ, derived localparam = (WIDTH+1)/2, result bits searched in sqrt mode.
- NB_CB, derived localparam = (WIDTH+2)/3, result bits searched in cbrt mode.
- PW, derived localparam = 2*WIDTH, power/product register width; no overflow possible.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- mode  in  1  0 = square root, 1 = cube root; latched with start.
- x_bi  in  WIDTH  operand; latched with start.
- busy  out  1  high from the cycle after accept until DONE inclusive.
- done  out  1  one-cycle pulse when y_bo is updated.
- y_bo  out  RW  result; holds its value until the next done.
- rem_bo  out  WIDTH  remainder x - y^n; present only with ROOT_REM_EN.

Behaviour:
Reset:
- rst low asynchronously forces state=IDLE and clears busy, done, y_bo, rem_bo and all internal registers.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Operation resumes on the first clk edge after rst rises.

States:
- IDLE:
  - start=1 latches x, mode; res=0; bit index k=NB-1 (NB per mode); goes to TRY.
  - start while busy is ignored; there is no queuing.
- TRY (1 cycle):
  - cand = res | (1<<k); pow = cand (zero-extended to PW).
  - mul count = n-1 (n=2 sqrt, n=3 cbrt); goes to MUL.
- MUL: per multiply, 1 launch cycle plus exactly RW compute cycles in the sub-module; pow = pow*cand.
  - Decrement count; when 0 go to CMP, else relaunch.
- CMP (1 cycle):
  - If pow <= x: res = cand and accepted power = pow.
  - If k==0 go to DONE, else k=k-1 and go to TRY.
- DONE (1 cycle):
  - y_bo = res zero-extended; done=1; busy drops next cycle; return to IDLE.
  - A start asserted in DONE is ignored. Earliest accept is the cycle after done.

Latency:
- Accept edge to done edge = NB*(2+(n-1)*(RW+1)) + 1.
- WIDTH=16: sqrt 8*(2+9)+1 = 89 cycles; cbrt 6*(2+18)+1 = 121 cycles.

Arithmetic:
- Unsigned only.
- Comparison is on the full PW width.
- Result is always the exact floor root; bits above NB are 0.

Boundaries:
- x=0 gives y=0; x=1 gives y=1.
- x = all-ones gives the max root (WIDTH=16: sqrt 255, cbrt 40).
- Back-to-back requests are accepted with 1 idle cycle between done and the next accept.

Optional Feature:
- Macro: ROOT_REM_EN.
- Defined:
  - Port rem_bo exists.
  - In DONE, rem_bo = x - accepted power (WIDTH bits), updated with y_bo; reset value 0.
  - Latency is unchanged.
- Undefined:
  - Port rem_bo and the accepted-power register are absent.
  - All other behaviour is identical.

Decomposition:
- Package nroot_pkg:
  - state enum {IDLE, TRY, MUL, CMP, DONE}.
  - Mode codes MODE_SQRT=1'b0, MODE_CBRT=1'b1.
  - Helper functions for NB per mode.
- Sub-module nroot_mul: shift-add multiplier.
  - Multiplicand PW bits, multiplier RW bits.
  - start/busy handshake; fixed RW compute cycles; product truncated to PW (no truncation occurs in range).

Test Plan:
- WIDTH=16, sqrt, x=65535 -> y_bo=255, done exactly 89 cycles after accept; with ROOT_REM_EN, rem_bo=510.
- WIDTH=16, cbrt, x=64000 -> y_bo=40 at 121 cycles; then x=63999 -> y_bo=39 (rem 4680 with ROOT_REM_EN).
- x=0 and x=1 in both modes -> y_bo=0 and 1 respectively; busy timing identical to other operands.
- start pulsed mid-operation, and during DONE, with a different x -> ignored; first result unaffected, single done.
- rst driven low asynchronously (off clock edge) during MUL -> busy/done/y_bo=0 immediately, no done; new request after release gives the correct result.
- Random sweep, WIDTH=8 and WIDTH=16, both modes -> y^n <= x < (y+1)^n for every result.
